// File: rtl/i2c_burst_reader.sv
// I2C master: write register address, repeated start, then read a burst of bytes into a buffer.
// Define I2C_NACK_RETRY_EN to retry NACKed address bytes (up to 3 retries) before flagging ack_err.
module i2c_burst_reader #(
  parameter int         DIV      = 125,
  parameter logic [6:0] DEV_ADDR = 7'h76,
  parameter int         MAX_LEN  = 8,
  parameter int         LW       = $clog2(MAX_LEN) + 1,
  localparam int        IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [7:0]    reg_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          ack_err,
  output logic          scl,
  output logic          tristate,
  inout  wire           sda,
  input  logic [IW-1:0] rd_idx,
  output logic [7:0]    data
);

  localparam int DW = $clog2(DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ACK_AW, S_REG, S_ACK_R, S_RSTART,
    S_ADDR_R, S_ACK_AR, S_READ, S_MACK, S_STOP, S_FIN
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_qdiv;
  logic [1:0]    r_q;
  logic [2:0]    r_bit;
  logic [7:0]    r_reg;
  logic [LW-1:0] r_len, r_n;
  logic [6:0]    r_shift;
  logic          r_ack, r_ack_err, r_scl, r_tri;
  logic [1:0]    r_retry;
  logic          r_again;
  logic [7:0]    r_buf [MAX_LEN];

  logic          w_sda_in, w_active, w_qend, w_bit_end, w_sample, w_last;
  logic          w_scl, w_tri, w_nack, w_retry, w_tx_bit, w_byte_st, w_ack_st;
  logic [7:0]    w_byte;
  logic [LW-1:0] w_len_clamp;

  assign w_sda_in    = sda;
  assign w_active    = (r_state != S_IDLE) && (r_state != S_FIN);
  assign w_qend      = (r_qdiv == DW'(DIV - 1));
  assign w_bit_end   = w_qend && (r_q == 2'd3);
  assign w_sample    = (r_q == 2'd3) && (r_qdiv == '0);
  assign w_last      = ((r_n + LW'(1)) == r_len);
  assign w_len_clamp = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
  assign w_byte_st   = (r_state == S_ADDR_W) || (r_state == S_REG) ||
                       (r_state == S_ADDR_R) || (r_state == S_READ);
  assign w_ack_st    = (r_state == S_ACK_AW) || (r_state == S_ACK_R) || (r_state == S_ACK_AR);

  always_comb begin
    w_state_nxt = r_state;
    w_scl       = 1'b1;
    w_tri       = 1'b1;
    w_nack      = 1'b0;
    w_retry     = 1'b0;
    case (r_state)
      S_REG:    w_byte = r_reg;
      S_ADDR_R: w_byte = {DEV_ADDR, 1'b1};
      default:  w_byte = {DEV_ADDR, 1'b0};
    endcase
    w_tx_bit = w_byte[3'd7 - r_bit];
    case (r_state)
      S_IDLE: if (en) w_state_nxt = (w_len_clamp == '0) ? S_FIN : S_START;
      // SCL stays high from idle; SDA falls at the middle of the bit time
      S_START: begin
        w_tri = ~r_q[1];
        if (w_bit_end) w_state_nxt = S_ADDR_W;
      end
      S_ADDR_W, S_REG, S_ADDR_R: begin
        w_scl = r_q[1];
        w_tri = w_tx_bit;
        if (w_bit_end && (r_bit == 3'd7))
          w_state_nxt = (r_state == S_ADDR_W) ? S_ACK_AW :
                        (r_state == S_REG)    ? S_ACK_R  : S_ACK_AR;
      end
      S_ACK_AW, S_ACK_R, S_ACK_AR: begin
        w_scl = r_q[1];
        if (w_bit_end) begin
          if (r_ack) begin
            w_state_nxt = S_STOP;
`ifdef I2C_NACK_RETRY_EN
            if ((r_state != S_ACK_R) && (r_retry != 2'd3)) w_retry = 1'b1;
            else                                           w_nack  = 1'b1;
`else
            w_nack = 1'b1;
`endif
          end else begin
            w_state_nxt = (r_state == S_ACK_AW) ? S_REG :
                          (r_state == S_ACK_R)  ? S_RSTART : S_READ;
          end
        end
      end
      S_RSTART: begin
        w_scl = (r_q != 2'd0);
        w_tri = ~r_q[1];
        if (w_bit_end) w_state_nxt = S_ADDR_R;
      end
      S_READ: begin
        w_scl = r_q[1];
        if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = S_MACK;
      end
      S_MACK: begin
        w_scl = r_q[1];
        w_tri = w_last;
        if (w_bit_end) w_state_nxt = w_last ? S_STOP : S_READ;
      end
      S_STOP: begin
        w_scl = r_q[1];
        w_tri = (r_q == 2'd3);
        if (w_bit_end) w_state_nxt = r_again ? S_START : S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_qdiv    <= '0;
      r_q       <= '0;
      r_bit     <= '0;
      r_reg     <= '0;
      r_len     <= '0;
      r_n       <= '0;
      r_shift   <= '0;
      r_ack     <= 1'b0;
      r_ack_err <= 1'b0;
      r_scl     <= 1'b1;
      r_tri     <= 1'b1;
      r_retry   <= '0;
      r_again   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_scl   <= w_scl;
      r_tri   <= w_tri;
      if (!w_active) begin
        r_qdiv <= '0;
        r_q    <= '0;
        r_bit  <= '0;
        if ((r_state == S_IDLE) && en) begin
          r_reg     <= reg_addr;
          r_len     <= w_len_clamp;
          r_n       <= '0;
          r_ack_err <= 1'b0;
          r_retry   <= '0;
          r_again   <= 1'b0;
        end
      end else begin
        r_qdiv <= w_qend ? '0 : r_qdiv + 1'b1;
        if (w_qend) r_q <= r_q + 1'b1;
        if (w_bit_end && w_byte_st) r_bit <= r_bit + 1'b1;
        if (w_sample && w_ack_st) r_ack <= w_sda_in;
        if (w_sample && (r_state == S_READ)) begin
          r_shift <= {r_shift[5:0], w_sda_in};
          if (r_bit == 3'd7) r_buf[r_n[IW-1:0]] <= {r_shift, w_sda_in};
        end
        if (w_bit_end && (r_state == S_MACK)) r_n <= r_n + 1'b1;
        if (w_nack) r_ack_err <= 1'b1;
        if (w_retry) begin
          r_retry <= r_retry + 1'b1;
          r_again <= 1'b1;
        end else if (w_bit_end && (r_state == S_STOP)) begin
          r_again <= 1'b0;
        end
      end
    end
  end

  assign busy     = w_active;
  assign done     = (r_state == S_FIN);
  assign ack_err  = r_ack_err;
  assign scl      = r_scl;
  assign tristate = r_tri;
  assign sda      = r_tri ? 1'bz : 1'b0;

  if ((1 << IW) > MAX_LEN) begin : g_idx_chk
    assign data = (32'(rd_idx) < MAX_LEN) ? r_buf[rd_idx] : 8'h00;
  end else begin : g_idx_full
    assign data = r_buf[rd_idx];
  end

endmodule

// File: tb/tb_i2c_burst_reader.sv
// Directed bench for i2c_burst_reader with a clocked I2C slave model (BME280-like register reads).
module tb_i2c_burst_reader;

  localparam int DIV     = 4;
  localparam int MAX_LEN = 8;
  localparam int LW      = 4;
  localparam int T       = 4 * DIV;

  logic          clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0]    reg_addr = '0;
  logic [LW-1:0] len = '0;
  logic [2:0]    rd_idx = '0;
  logic          busy, done, ack_err, scl, tristate;
  logic [7:0]    data;
  wire           sda;

  always #5 clk = ~clk;

  i2c_burst_reader #(.DIV(DIV), .DEV_ADDR(7'h76), .MAX_LEN(MAX_LEN), .LW(LW)) dut (
    .clk(clk), .rst(rst), .en(en), .reg_addr(reg_addr), .len(len), .busy(busy),
    .done(done), .ack_err(ack_err), .scl(scl), .tristate(tristate), .sda(sda),
    .rd_idx(rd_idx), .data(data)
  );

  logic slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave model: sampled on the falling clk edge, reacts to SCL/SDA transitions.
  logic [7:0] tbl [16] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18,
                           8'h29, 8'h3A, 8'h4B, 8'h5C, 8'h6D, 8'h7E, 8'h8F, 8'h90};
  logic [7:0] rx_log [16];
  logic       mack_log [16];
  int rx_n = 0, mack_n = 0, s_starts = 0, s_rstarts = 0, s_stops = 0;
  int s_nack = 0, s_base = 0, s_st = 0, s_bc = 0, s_k = 0, done_cnt = 0;
  logic p_scl = 1'b1, p_sda = 1'b1, cs, cd;
  logic s_inframe = 1'b0, s_first = 1'b0, s_fresh = 1'b0, s_ack = 1'b0, s_rd = 1'b0, s_mack = 1'b0;
  logic [7:0] s_sh = '0, s_tx = '0;

  always @(negedge clk) if (done) done_cnt++;

  always @(negedge clk) begin
    cs = scl;
    cd = sda;
    if (rst) begin
      slv_low = 1'b0; s_st = 0; s_inframe = 1'b0;
    end else if (p_scl && cs && p_sda && !cd) begin
      if (s_inframe) s_rstarts++; else s_starts++;
      s_fresh = !s_inframe;
      s_inframe = 1'b1; s_st = 1; s_bc = 0; s_first = 1'b1; slv_low = 1'b0;
    end else if (p_scl && cs && !p_sda && cd) begin
      s_stops++; s_inframe = 1'b0; s_st = 0; slv_low = 1'b0;
    end else if (!p_scl && cs) begin
      case (s_st)
        1: begin s_sh = {s_sh[6:0], cd}; s_bc++; end
        3: s_bc++;
        4: begin
          if (mack_n < 16) mack_log[mack_n] = cd;
          mack_n++; s_mack = cd;
        end
        default: ;
      endcase
    end else if (p_scl && !cs) begin
      case (s_st)
        1: if (s_bc == 8) begin
          if (rx_n < 16) rx_log[rx_n] = s_sh;
          rx_n++;
          s_ack = 1'b1;
          if (s_first && s_fresh && s_nack > 0) begin s_nack--; s_ack = 1'b0; end
          s_rd = s_first && s_sh[0];
          slv_low = s_ack; s_st = 2;
        end
        2: begin
          slv_low = 1'b0;
          if (!s_ack) s_st = 0;
          else if (s_rd) begin
            s_st = 3; s_bc = 0; s_k = 0; s_tx = tbl[(s_base + s_k) & 15]; slv_low = ~s_tx[7];
          end else begin s_st = 1; s_bc = 0; end
          s_first = 1'b0;
        end
        3: if (s_bc == 8) begin slv_low = 1'b0; s_st = 4; end
           else slv_low = ~s_tx[7 - s_bc];
        4: if (!s_mack) begin
          s_k++; s_tx = tbl[(s_base + s_k) & 15]; s_bc = 0; slv_low = ~s_tx[7]; s_st = 3;
        end else s_st = 0;
        default: ;
      endcase
    end
    p_scl = cs;
    p_sda = cd;
  end

  task automatic clear_logs();
    rx_n = 0; mack_n = 0; s_starts = 0; s_rstarts = 0; s_stops = 0;
  endtask

  task automatic go(input logic [7:0] ra, input logic [LW-1:0] ln, input int pulse_at, output int cyc);
    int n;
    @(negedge clk); reg_addr = ra; len = ln; en = 1'b1;
    @(negedge clk); en = 1'b0; n = 1;
    while (!done && n < 20000) begin
      en = (n == pulse_at);
      if (n == pulse_at) len = '0;
      @(negedge clk); n++;
    end
    en = 1'b0;
    cyc = done ? n - 1 : -1;
  endtask

  task automatic rdbuf(input int idx, output logic [7:0] v);
    @(negedge clk); rd_idx = 3'(idx); #1 v = data;
  endtask

  initial begin
    int cyc, dc;
    logic [7:0] v;
    logic hi;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_ackerr", ack_err, 0);
    chk("rst_scl", scl, 1); chk("rst_tri", tristate, 1); chk("rst_sda", sda, 1);
    for (int i = 0; i < MAX_LEN; i++) begin rdbuf(i, v); chk("rst_buf", v, 8'h00); end
    rst = 1'b0;

    // main burst, with an ignored en pulse while busy
    clear_logs(); s_base = 0; dc = done_cnt;
    go(8'hF7, 4'd3, 100, cyc);
    chk("main_cycles", cyc, T * 57);
    repeat (2) @(negedge clk);
    chk("main_done_pulses", done_cnt - dc, 1);
    chk("main_rx_n", rx_n, 3);
    chk("main_addr_w", rx_log[0], 8'hEC); chk("main_reg", rx_log[1], 8'hF7);
    chk("main_addr_r", rx_log[2], 8'hED);
    chk("main_starts", s_starts, 1); chk("main_rstarts", s_rstarts, 1); chk("main_stops", s_stops, 1);
    chk("main_mack_n", mack_n, 3);
    chk("main_mack0", mack_log[0], 0); chk("main_mack1", mack_log[1], 0); chk("main_mack2", mack_log[2], 1);
    rdbuf(0, v); chk("main_buf0", v, 8'hA1);
    rdbuf(1, v); chk("main_buf1", v, 8'hB2);
    rdbuf(2, v); chk("main_buf2", v, 8'hC3);
    rdbuf(3, v); chk("main_buf3_old", v, 8'h00);
    chk("main_ackerr", ack_err, 0); chk("main_busy_after", busy, 0);

    // len = 0, then en coinciding with done
    hi = 1'b1;
    @(negedge clk); reg_addr = 8'h55; len = '0; en = 1'b1;
    @(negedge clk);
    chk("len0_done", done, 1);
    if (!scl || !tristate) hi = 1'b0;
    len = 4'd3;
    @(negedge clk); en = 1'b0;
    chk("en_at_done_busy", busy, 0); chk("en_at_done_done", done, 0);
    repeat (4 * T) begin @(negedge clk); if (!scl || !tristate) hi = 1'b0; end
    chk("len0_bus_idle", hi, 1);
    rdbuf(0, v); chk("len0_buf0", v, 8'hA1);

    // len clamped to MAX_LEN
    clear_logs(); s_base = 0;
    go(8'h00, 4'd12, -1, cyc);
    chk("clamp_cycles", cyc, T * (30 + 9 * MAX_LEN));
    chk("clamp_mack_n", mack_n, MAX_LEN);
    chk("clamp_mack6", mack_log[6], 0); chk("clamp_mack7", mack_log[7], 1);
    for (int i = 3; i < MAX_LEN; i++) begin rdbuf(i, v); chk("clamp_buf", v, tbl[i]); end

`ifdef I2C_NACK_RETRY_EN
    // two NACKs then ACK: retried transaction completes
    clear_logs(); s_nack = 2; s_base = 4;
    go(8'hF7, 4'd3, -1, cyc);
    chk("retry_cycles", cyc, T * (11 + 11 + 57));
    chk("retry_starts", s_starts, 3); chk("retry_rstarts", s_rstarts, 1); chk("retry_stops", s_stops, 3);
    chk("retry_ackerr", ack_err, 0);
    rdbuf(0, v); chk("retry_buf0", v, 8'hE5);
    rdbuf(1, v); chk("retry_buf1", v, 8'hF6);
    rdbuf(2, v); chk("retry_buf2", v, 8'h07);
    rdbuf(3, v); chk("retry_buf3_old", v, 8'hD4);
    // four NACKs exhaust the retries
    clear_logs(); s_nack = 4;
    go(8'hF7, 4'd3, -1, cyc);
    chk("retry_fail_cycles", cyc, T * 44);
    chk("retry_fail_starts", s_starts, 4); chk("retry_fail_ackerr", ack_err, 1);
    chk("retry_fail_busy", busy, 0);
    s_nack = 0;
`else
    // address NACK aborts after one attempt
    clear_logs(); s_nack = 1;
    go(8'hF7, 4'd3, -1, cyc);
    chk("nack_cycles", cyc, T * 11);
    chk("nack_starts", s_starts, 1); chk("nack_stops", s_stops, 1); chk("nack_rx_n", rx_n, 1);
    chk("nack_ackerr", ack_err, 1); chk("nack_busy", busy, 0);
    rdbuf(0, v); chk("nack_buf0", v, 8'hA1);
    s_nack = 0;
`endif

    // new transaction clears ack_err, shorter len leaves upper bytes
    clear_logs(); s_base = 8;
    go(8'h10, 4'd2, -1, cyc);
    chk("short_cycles", cyc, T * 48);
    chk("short_reg", rx_log[1], 8'h10);
    chk("short_ackerr", ack_err, 0);
    rdbuf(0, v); chk("short_buf0", v, 8'h29);
    rdbuf(1, v); chk("short_buf1", v, 8'h3A);
`ifdef I2C_NACK_RETRY_EN
    rdbuf(2, v); chk("short_buf2_old", v, 8'h07);
`else
    rdbuf(2, v); chk("short_buf2_old", v, 8'hC3);
`endif

    // reset in the middle of READ
    s_base = 0;
    @(negedge clk); reg_addr = 8'h20; len = 4'd3; en = 1'b1;
    @(negedge clk); en = 1'b0;
    repeat (31 * T + 4) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_scl", scl, 1); chk("midrst_tri", tristate, 1); chk("midrst_busy", busy, 0);
    rdbuf(0, v); chk("midrst_buf0", v, 8'h00);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    go(8'h20, 4'd1, -1, cyc);
    chk("after_rst_cycles", cyc, T * 39);
    chk("after_rst_ackerr", ack_err, 0);
    rdbuf(0, v); chk("after_rst_buf0", v, 8'hA1);
    rdbuf(1, v); chk("after_rst_buf1", v, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
